// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared types for the common data bus producer and its snoopers
package cdb_arbiter_pkg;

    typedef enum logic [1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_MUL  = 2'd2,
        FU_LSU  = 2'd3
    } e_functional_unit;

    localparam int FU_COUNT       = 4;
    localparam int CDB_DATA_WIDTH = 64;

    typedef struct packed {
        logic                      valid;
        logic [CDB_DATA_WIDTH-1:0] value;
        e_functional_unit          rs;
    } cdb_bcast_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo: per-unit result buffer with flush; full deasserts ready even when popping
module cdb_result_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  push_ready_o,
    output logic                  not_empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push, pop;

    assign push_ready_o = count_q != CW'(DEPTH);
    assign not_empty_o  = count_q != '0;
    assign head_o       = mem_q[rd_ptr_q];
    assign push         = push_i && push_ready_o && !flush_i;
    assign pop          = pop_i && not_empty_o && !flush_i;

    always_comb begin
        count_d  = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
        wr_ptr_d = flush_i ? '0 : !push ? wr_ptr_q : wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = flush_i ? '0 : !pop ? rd_ptr_q : rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers unit results and broadcasts one per cycle on the CDB, round-robin
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_UNITS  = 4,
    parameter int DEPTH      = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic [NUM_UNITS-1:0]                 fu_valid_i,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] fu_value_i,
    output logic [NUM_UNITS-1:0]                 fu_ready_o,
    output logic                                 bcast_valid_o,
    output logic [DATA_WIDTH-1:0]                bcast_value_o,
    output e_functional_unit                     bcast_rs_o
);
    localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
    localparam int RW = $bits(e_functional_unit);

    logic [NUM_UNITS-1:0]  not_empty, pop;
    logic [DATA_WIDTH-1:0] head [NUM_UNITS];
    logic [UW-1:0]         rr_ptr_q, rr_ptr_d, winner;
    logic                  found, fire;
    int                    idx;
    logic                  bcast_valid_q, bcast_valid_d;
    logic [DATA_WIDTH-1:0] bcast_value_q, bcast_value_d;
    e_functional_unit      bcast_rs_q, bcast_rs_d;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_fifo
        cdb_result_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush_i),
            .push_i      (fu_valid_i[i]),
            .push_data_i (fu_value_i[i]),
            .pop_i       (pop[i]),
            .push_ready_o(fu_ready_o[i]),
            .not_empty_o (not_empty[i]),
            .head_o      (head[i])
        );
    end

    // First non-empty unit at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_UNITS;
            if (!found && not_empty[idx]) begin
                found  = 1'b1;
                winner = UW'(idx);
            end
        end
    end

    always_comb begin
        fire          = found && !flush_i;
        pop           = fire ? NUM_UNITS'(1) << winner : '0;
        bcast_valid_d = fire;
        bcast_value_d = fire ? head[winner] : bcast_value_q;
        bcast_rs_d    = fire ? e_functional_unit'(RW'(winner)) : bcast_rs_q;
        rr_ptr_d      = !fire ? rr_ptr_q : winner == UW'(NUM_UNITS - 1) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            bcast_valid_q <= 1'b0;
            bcast_value_q <= '0;
            bcast_rs_q    <= e_functional_unit'(0);
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            bcast_valid_q <= bcast_valid_d;
            bcast_value_q <= bcast_value_d;
            bcast_rs_q    <= bcast_rs_d;
        end
    end

    assign bcast_valid_o = bcast_valid_q;
    assign bcast_value_o = bcast_value_q;
    assign bcast_rs_o    = bcast_rs_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of buffering, round-robin, backpressure, flush and reset
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush_i = 1'b0;
    logic [3:0]       fu_valid_i = '0;
    logic [3:0][63:0] fu_value_i = '0;
    logic [3:0]       fu_ready_o;
    logic             bcast_valid_o;
    logic [63:0]      bcast_value_o;
    e_functional_unit bcast_rs_o;
    int               checks = 0;
    int               errors = 0;

    cdb_arbiter #(.DATA_WIDTH(64), .NUM_UNITS(4), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .fu_valid_i   (fu_valid_i),
        .fu_value_i   (fu_value_i),
        .fu_ready_o   (fu_ready_o),
        .bcast_valid_o(bcast_valid_o),
        .bcast_value_o(bcast_value_o),
        .bcast_rs_o   (bcast_rs_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bc(input string tag, input logic [63:0] v, input logic [1:0] rs);
        chk({tag, ".valid"}, 64'(bcast_valid_o), 64'd1);
        chk({tag, ".value"}, bcast_value_o, v);
        chk({tag, ".rs"}, 64'(bcast_rs_o), 64'(rs));
    endtask

    task automatic idle(input string tag);
        chk({tag, ".valid"}, 64'(bcast_valid_o), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Single result
        do_reset();
        idle("rst");
        chk("rst.value", bcast_value_o, 64'd0);
        chk("rst.rs", 64'(bcast_rs_o), 64'd0);
        chk("rst.ready", 64'(fu_ready_o), 64'hf);
        fu_valid_i = 4'b0010; fu_value_i[1] = 64'hDEAD;
        tick();
        fu_valid_i = '0;
        idle("single.e0");
        tick(); bc("single.e1", 64'hDEAD, 2'd1);
        tick(); idle("single.e2");

        // Contention from rr_ptr 0
        do_reset();
        fu_valid_i = 4'b1111;
        fu_value_i = {64'h13, 64'h12, 64'h11, 64'h10};
        tick();
        fu_valid_i = '0;
        idle("cont.e0");
        tick(); bc("cont.b0", 64'h10, 2'd0);
        tick(); bc("cont.b1", 64'h11, 2'd1);
        tick(); bc("cont.b2", 64'h12, 2'd2);
        tick(); bc("cont.b3", 64'h13, 2'd3);
        tick(); idle("cont.end");

        // Backpressure on unit 2
        do_reset();
        fu_valid_i = 4'b1111;
        fu_value_i = {64'hD0, 64'hC0, 64'hB0, 64'hA0};
        tick();
        fu_value_i = {64'hD1, 64'hC1, 64'hB1, 64'hA1};
        tick();
        bc("bp.e1", 64'hA0, 2'd0);
        chk("bp.ready_full", 64'(fu_ready_o), 64'b0001);
        fu_valid_i = 4'b0100; fu_value_i[2] = 64'hC2;
        tick(); bc("bp.e2", 64'hB0, 2'd1);
        chk("bp.ready2_held", 64'(fu_ready_o[2]), 64'd0);
        tick(); bc("bp.e3", 64'hC0, 2'd2);
        chk("bp.ready2_back", 64'(fu_ready_o[2]), 64'd1);
        tick(); bc("bp.e4", 64'hD0, 2'd3);
        chk("bp.ready2_full", 64'(fu_ready_o[2]), 64'd0);
        fu_valid_i = '0;
        tick(); bc("bp.e5", 64'hA1, 2'd0);
        tick(); bc("bp.e6", 64'hB1, 2'd1);
        tick(); bc("bp.e7", 64'hC1, 2'd2);
        tick(); bc("bp.e8", 64'hD1, 2'd3);
        tick(); bc("bp.e9", 64'hC2, 2'd2);
        tick(); idle("bp.e10");

        // Round-robin wrap: rr_ptr is now 3
        fu_valid_i = 4'b1001;
        fu_value_i[0] = 64'h40; fu_value_i[3] = 64'h43;
        tick();
        fu_valid_i = '0;
        tick(); bc("rr.f1", 64'h43, 2'd3);
        fu_valid_i = 4'b0011;
        fu_value_i[0] = 64'h50; fu_value_i[1] = 64'h51;
        tick(); bc("rr.f2", 64'h40, 2'd0);
        fu_valid_i = '0;
        tick(); bc("rr.ptr1", 64'h51, 2'd1);
        tick(); bc("rr.f4", 64'h50, 2'd0);
        tick(); idle("rr.f5");

        // Flush with simultaneous push
        fu_valid_i = 4'b1110;
        fu_value_i = {64'h63, 64'h62, 64'h61, 64'h0};
        tick();
        fu_valid_i = 4'b0001; fu_value_i[0] = 64'h55; flush_i = 1'b1;
        tick();
        fu_valid_i = '0; flush_i = 1'b0;
        idle("flush.g1");
        chk("flush.ready", 64'(fu_ready_o), 64'hf);
        tick(); idle("flush.g2");
        tick(); idle("flush.g3");

        // Reset mid-burst; rr_ptr is 1 after flush
        fu_valid_i = 4'b1111;
        fu_value_i = {64'h73, 64'h72, 64'h71, 64'h70};
        tick();
        fu_valid_i = '0;
        tick(); bc("mid.h1", 64'h71, 2'd1);
        do_reset();
        idle("mid.rst");
        chk("mid.value", bcast_value_o, 64'd0);
        chk("mid.rs", 64'(bcast_rs_o), 64'd0);
        for (int n = 0; n < 3; n++) begin
            tick(); idle("mid.after");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
